cpu_mc: RTL and testbench
=========================

// Module: cpu_mc
// PURPOSE
//   Multi-cycle MIPS-subset core: successor to the single-cycle cpu top. Fetch, decode,
//   execute, memory and writeback run as FSM states over one shared ALU. Instruction and
//   data memory sit behind req/ack handshakes, so wait-state memories are supported.
//   Holds an internal 32x32 register file and a memory-mapped LED register of N_LEDS bits.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   LED_ADDR  32'hFFFF_FF00  word address of the LED register (not forwarded to dmem)
//   N_LEDS    8              LED register width, 1..32
// PORTS
//   clk         in   1       clock, rising edge
//   reset       in   1       synchronous, active-high
//   imem_req    out  1       instruction fetch request
//   imem_addr   out  32      fetch address (= PC, bits[1:0]=0)
//   imem_rdata  in   32      instruction word, valid when imem_ack=1
//   imem_ack    in   1       fetch complete
//   dmem_req    out  1       data access request
//   dmem_we     out  1       1=store, 0=load; valid while dmem_req=1
//   dmem_addr   out  32      data address, bits[1:0] forced 0
//   dmem_wdata  out  32      store data
//   dmem_rdata  in   32      load data, valid when dmem_ack=1
//   dmem_ack    in   1       data access complete
//   leds        out  N_LEDS  LED register
//   retire      out  1       1-cycle pulse per completed instruction
//   halted      out  1       core stopped on unsupported opcode
// BEHAVIOUR
//   Reset (sync, active-high): PC=RESET_PC, state=FETCH, leds=0, all req/retire/halted=0,
//     regfile not cleared. Reset asserted mid-access drops req next edge, no write.
//   ISA: add sub and or slt (R), addi andi ori lui slti, lw sw, beq bne, j. Unknown -> HALT.
//   States: FETCH -> DECODE -> EXEC -> {MEM} -> {WB} -> FETCH; HALT absorbing until reset.
//   FETCH: imem_req=1, imem_addr=PC held stable until imem_ack sampled 1 (ack may arrive the
//     same cycle as req); latch IR, PC<=PC+4.
//   DECODE: read rs,rt into A,B; compute branch target PC+4+(sext(imm)<<2); decode opcode.
//   EXEC: ALU op. beq/bne: PC<=target if taken, retire, ->FETCH. j: PC<={PC[31:28],idx,2'b00},
//     retire, ->FETCH. lw/sw: address A+sext(imm) ->MEM. Others ->WB.
//   MEM: addr==LED_ADDR: sw sets leds<=B[N_LEDS-1:0] (sw retires, ->FETCH); lw gets
//     zero-extended leds (->WB); no dmem_req either way. Else dmem_req=1 with addr/we/wdata
//     stable until dmem_ack; sw retires ->FETCH, lw latches rdata ->WB.
//   WB: write rd (R-type) or rt (I-type/lw); writes to $0 discarded; retire; ->FETCH.
//   Latency with zero-wait memory: branch/jump 3, R/I-ALU 4, sw 4, lw 5 cycles; each wait
//     cycle of ack adds one.
//   Arithmetic: 32-bit wrap, no overflow trap. slt/slti signed. addi/slti sign-extend imm;
//     andi/ori zero-extend; lui = imm<<16. Zero flag = (A-B)==0.
//   Register read in DECODE sees writes from previous WB (no same-cycle hazard possible).
//   halted=1 from the cycle after DECODE sees unsupported opcode; no req while halted.
// TESTING
//   addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> $3=2, 3 retire pulses, 12 cycles zero-wait.
//   sw $3 to LED_ADDR, N_LEDS=8 -> leds=8'h02, dmem_req never asserted; lw back -> 32'h2.
//   lw with dmem_ack delayed 3 cycles -> dmem_addr/req held stable 4 cycles, lw takes 8 cycles.
//   beq $1,$1,-1 -> PC loops to same address, retire every 3 cycles; bne untaken -> PC+4.
//   add $0,$1,$1 then lw/sw using $0 base -> $0 reads 0; slt $4,$2,$1 -> $4=1 (signed).
//   opcode 6'h3F -> halted=1, imem_req stays 0; reset mid-lw wait -> dmem_req=0, PC=RESET_PC.

Source files
------------

// File: rtl/cpu_mc_if.sv
// Instruction and data memory req/ack bus between cpu_mc (master) and its memories (slave).
interface cpu_mc_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/cpu_mc.sv
// Multi-cycle MIPS-subset core: fetch/decode/exec/mem/wb FSM over req/ack memories,
// internal 32x32 register file and a memory-mapped LED register.
module cpu_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] LED_ADDR = 32'hFFFF_FF00,
    parameter int unsigned N_LEDS   = 8
) (
    input  logic              clk,
    input  logic              reset,
    cpu_mc_if.master          bus,
    output logic [N_LEDS-1:0] leds,
    output logic              retire,
    output logic              halted
);
    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

    localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpBeq = 6'h04, OpBne = 6'h05;
    localparam logic [5:0] OpAddi = 6'h08, OpSlti = 6'h0A, OpAndi = 6'h0C, OpOri = 6'h0D;
    localparam logic [5:0] OpLui = 6'h0F, OpLw = 6'h23, OpSw = 6'h2B;
    localparam logic [5:0] FnAdd = 6'h20, FnSub = 6'h22, FnAnd = 6'h24, FnOr = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0]       tgt_q, tgt_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic [31:0]       rf_q [32];
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sext, imm_zext, mem_addr, leds_ext, alu_res;
    logic        op_valid, is_led, zero, imem_req, dmem_req, retire_c;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext = {16'h0000, ir_q[15:0]};
    assign mem_addr = {alu_q[31:2], 2'b00};
    assign is_led   = (mem_addr == LED_ADDR);
    assign zero     = ((a_q - b_q) == 32'h0);

    always_comb begin
        leds_ext               = '0;
        leds_ext[N_LEDS-1:0]   = leds_q;
    end

    always_comb begin
        op_valid = 1'b0;
        case (opcode)
            OpRtype: op_valid = (shamt == 5'd0) &&
                                (funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt});
            OpJ, OpBeq, OpBne, OpAddi, OpSlti, OpAndi, OpOri, OpLui, OpLw, OpSw:
                op_valid = 1'b1;
            default: op_valid = 1'b0;
        endcase
    end

    // Single ALU: R/I arithmetic and lw/sw effective address.
    always_comb begin
        alu_res = '0;
        case (opcode)
            OpRtype: begin
                case (funct)
                    FnAdd:   alu_res = a_q + b_q;
                    FnSub:   alu_res = a_q - b_q;
                    FnAnd:   alu_res = a_q & b_q;
                    FnOr:    alu_res = a_q | b_q;
                    FnSlt:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
                    default: alu_res = '0;
                endcase
            end
            OpAddi, OpLw, OpSw: alu_res = a_q + imm_sext;
            OpSlti:  alu_res = {31'b0, $signed(a_q) < $signed(imm_sext)};
            OpAndi:  alu_res = a_q & imm_zext;
            OpOri:   alu_res = a_q | imm_zext;
            OpLui:   alu_res = {ir_q[15:0], 16'h0000};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        tgt_d    = tgt_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        leds_d   = leds_q;
        rf_we    = 1'b0;
        rf_waddr = (opcode == OpRtype) ? rd : rt;
        rf_wdata = (opcode == OpLw) ? mdr_q : alu_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        retire_c = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d     = (rs == 5'd0) ? 32'h0 : rf_q[rs];
                b_d     = (rt == 5'd0) ? 32'h0 : rf_q[rt];
                tgt_d   = pc_q + {imm_sext[29:0], 2'b00};
                state_d = op_valid ? StExec : StHalt;
            end
            StExec: begin
                alu_d = alu_res;
                case (opcode)
                    OpBeq, OpBne: begin
                        if ((opcode == OpBeq) == zero) pc_d = tgt_q;
                        retire_c = 1'b1;
                        state_d  = StFetch;
                    end
                    OpJ: begin
                        pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
                        retire_c = 1'b1;
                        state_d  = StFetch;
                    end
                    OpLw, OpSw: state_d = StMem;
                    default:    state_d = StWb;
                endcase
            end
            StMem: begin
                if (is_led) begin
                    if (opcode == OpSw) begin
                        leds_d   = b_q[N_LEDS-1:0];
                        retire_c = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        mdr_d   = leds_ext;
                        state_d = StWb;
                    end
                end else begin
                    dmem_req = 1'b1;
                    if (bus.dmem_ack) begin
                        if (opcode == OpSw) begin
                            retire_c = 1'b1;
                            state_d  = StFetch;
                        end else begin
                            mdr_d   = bus.dmem_rdata;
                            state_d = StWb;
                        end
                    end
                end
            end
            StWb: begin
                rf_we    = (rf_waddr != 5'd0);
                retire_c = 1'b1;
                state_d  = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
        // Reset wins over any in-flight access in the same cycle.
        if (reset) begin
            rf_we    = 1'b0;
            imem_req = 1'b0;
            dmem_req = 1'b0;
            retire_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tgt_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tgt_q   <= tgt_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            leds_q  <= leds_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end

    assign bus.imem_req   = imem_req;
    assign bus.imem_addr  = {pc_q[31:2], 2'b00};
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = (opcode == OpSw);
    assign bus.dmem_addr  = mem_addr;
    assign bus.dmem_wdata = b_q;
    assign leds           = leds_q;
    assign retire         = retire_c;
    assign halted         = (state_q == StHalt) && !reset;
endmodule

// File: tb/tb_cpu_mc.sv
// Bench for cpu_mc: directed programs plus random programs checked against an ISA-level model.
module tb_cpu_mc;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR = 32'hFFFF_FF00;
    localparam logic [31:0] HALT_INS = 32'hFC00_0000;

    logic       clk, reset, retire, halted;
    logic [7:0] leds;
    cpu_mc_if   bus ();

    cpu_mc #(.RESET_PC(RESET_PC), .LED_ADDR(LED_ADDR), .N_LEDS(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .leds(leds), .retire(retire), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total, bad;
    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic [31:0] exp_fetch [$];
    logic        exp_dm_we [$];
    logic [31:0] exp_dm_addr [$];
    logic [31:0] exp_dm_wdata [$];
    int          m_retire;
    logic [7:0]  m_leds;
    int cyc, n_retire, n_fetch, n_dm, dm_req_cycles;
    int im_wmin, im_wmax, dm_wmin, dm_wmax, im_wait, dm_wait;
    bit trace_on, im_busy, dm_busy, dm_we_l;
    logic [31:0] im_addr_l, dm_addr_l, dm_wdata_l, last_fetch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // ISA-level interpreter producing the expected fetch and data-access trace.
    task automatic model_run();
        logic [31:0] mr [32];
        logic [31:0] mdm [64];
        logic [31:0] pc, npc, ins, a, b, sx, zx, addr;
        logic [4:0]  rs, rt, rd;
        bit done;
        for (int i = 0; i < 32; i++) mr[i] = 32'h0;
        for (int i = 0; i < 64; i++) mdm[i] = dmem[i];
        exp_fetch.delete(); exp_dm_we.delete(); exp_dm_addr.delete(); exp_dm_wdata.delete();
        m_retire = 0; m_leds = 8'h00; pc = RESET_PC; done = 0;
        for (int s = 0; s < 1000 && !done; s++) begin
            ins = imem[pc[7:2]];
            exp_fetch.push_back(pc);
            rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
            a = mr[rs]; b = mr[rt];
            sx = {{16{ins[15]}}, ins[15:0]}; zx = {16'h0, ins[15:0]};
            npc = pc + 4;
            addr = a + sx; addr[1:0] = 2'b00;
            case (ins[31:26])
                6'h00: case (ins[5:0])
                    6'h20: mr[rd] = a + b;
                    6'h22: mr[rd] = a - b;
                    6'h24: mr[rd] = a & b;
                    6'h25: mr[rd] = a | b;
                    6'h2A: mr[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: done = 1;
                endcase
                6'h08: mr[rt] = a + sx;
                6'h0A: mr[rt] = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
                6'h0C: mr[rt] = a & zx;
                6'h0D: mr[rt] = a | zx;
                6'h0F: mr[rt] = {ins[15:0], 16'h0};
                6'h23: if (addr == LED_ADDR) mr[rt] = {24'h0, m_leds};
                       else begin
                           exp_dm_we.push_back(1'b0); exp_dm_addr.push_back(addr);
                           exp_dm_wdata.push_back(32'h0); mr[rt] = mdm[addr[7:2]];
                       end
                6'h2B: if (addr == LED_ADDR) m_leds = b[7:0];
                       else begin
                           exp_dm_we.push_back(1'b1); exp_dm_addr.push_back(addr);
                           exp_dm_wdata.push_back(b); mdm[addr[7:2]] = b;
                       end
                6'h04: if (a == b) npc = npc + (sx << 2);
                6'h05: if (a != b) npc = npc + (sx << 2);
                6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
                default: done = 1;
            endcase
            mr[0] = 32'h0;
            if (!done) begin m_retire++; pc = npc; end
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick();
        int idx;
        #1;
        cyc++;
        if (bus.imem_req) begin
            if (!im_busy) begin
                im_busy = 1; im_addr_l = bus.imem_addr; last_fetch = bus.imem_addr;
                im_wait = $urandom_range(im_wmax, im_wmin);
                if (trace_on) begin
                    idx = n_fetch; n_fetch++;
                    if (idx < exp_fetch.size()) check("fetch_pc", bus.imem_addr, exp_fetch[idx]);
                    else check("fetch_extra", n_fetch, exp_fetch.size());
                end
            end else check("imem_hold", bus.imem_addr, im_addr_l);
            if (im_wait == 0) begin
                bus.imem_ack = 1'b1; bus.imem_rdata = imem[bus.imem_addr[7:2]]; im_busy = 0;
            end else begin
                bus.imem_ack = 1'b0; im_wait--;
            end
        end else bus.imem_ack = 1'b0;
        if (bus.dmem_req) begin
            dm_req_cycles++;
            if (!dm_busy) begin
                dm_busy = 1; dm_we_l = bus.dmem_we; dm_addr_l = bus.dmem_addr;
                dm_wdata_l = bus.dmem_wdata; dm_wait = $urandom_range(dm_wmax, dm_wmin);
                if (trace_on) begin
                    idx = n_dm; n_dm++;
                    if (idx < exp_dm_addr.size()) begin
                        check("dm_we", {31'b0, bus.dmem_we}, {31'b0, exp_dm_we[idx]});
                        check("dm_addr", bus.dmem_addr, exp_dm_addr[idx]);
                        if (exp_dm_we[idx]) check("dm_wdata", bus.dmem_wdata, exp_dm_wdata[idx]);
                    end else check("dm_extra", n_dm, exp_dm_addr.size());
                end
            end else begin
                check("dm_hold", (bus.dmem_addr ^ dm_addr_l) | (bus.dmem_wdata ^ dm_wdata_l) |
                      {31'b0, bus.dmem_we ^ dm_we_l}, 32'h0);
            end
            if (dm_wait == 0) begin
                bus.dmem_ack = 1'b1; dm_busy = 0;
                if (bus.dmem_we) dmem[bus.dmem_addr[7:2]] = bus.dmem_wdata;
                else bus.dmem_rdata = dmem[bus.dmem_addr[7:2]];
            end else begin
                bus.dmem_ack = 1'b0; dm_wait--;
            end
        end else bus.dmem_ack = 1'b0;
        #1;
        if (retire) n_retire++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; im_busy = 0; dm_busy = 0;
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
        check("rst_dmem_req", {31'b0, bus.dmem_req}, 32'h0);
        check("rst_retire", {31'b0, retire}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_leds", {24'h0, leds}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0; n_retire = 0; n_fetch = 0; n_dm = 0; dm_req_cycles = 0;
    endtask

    task automatic start_prog();
        model_run();
        do_reset();
    endtask

    task automatic finish_prog(input int budget);
        while (!halted && cyc < budget) tick();
        check("halted", {31'b0, halted}, 32'h1);
        check("fetch_cnt", n_fetch, exp_fetch.size());
        check("dmem_cnt", n_dm, exp_dm_addr.size());
        check("retire_cnt", n_retire, m_retire);
        check("leds", {24'h0, leds}, {24'h0, m_leds});
        repeat (4) begin
            tick();
            check("halt_noreq", {31'b0, bus.imem_req | bus.dmem_req}, 32'h0);
        end
    endtask

    task automatic set_waits(input int imin, input int imax, input int dmin, input int dmax);
        im_wmin = imin; im_wmax = imax; dm_wmin = dmin; dm_wmax = dmax;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = HALT_INS;
    endtask

    task automatic gen_prog();
        logic [4:0] rs, rt, rd;
        logic [5:0] fn, op;
        int kind;
        clear_imem();
        for (int r = 1; r < 8; r++) imem[r-1] = i_ins(6'h08, 5'd0, 5'(r), 16'($urandom));
        for (int i = 7; i < 31; i++) begin
            kind = $urandom_range(0, 9);
            rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: begin fn = 6'h20; op = 6'h08; end
                1: begin fn = 6'h22; op = 6'h0A; end
                2: begin fn = 6'h24; op = 6'h0C; end
                3: begin fn = 6'h25; op = 6'h0D; end
                default: begin fn = 6'h2A; op = 6'h0F; end
            endcase
            case (kind)
                0, 1, 2: imem[i] = r_ins(fn, rs, rt, rd);
                3, 4:    imem[i] = i_ins(op, rs, rt, 16'($urandom));
                5: imem[i] = i_ins(6'h2B, 5'd0, rt, 16'(4 * $urandom_range(0, 31)));
                6: imem[i] = i_ins(6'h23, 5'd0, rt, 16'(4 * $urandom_range(0, 31)));
                7: imem[i] = i_ins($urandom_range(0, 1) ? 6'h2B : 6'h23, 5'd0, rt, 16'hFF00);
                8: imem[i] = i_ins($urandom_range(0, 1) ? 6'h04 : 6'h05, rs, rt,
                                   16'($urandom_range(0, 3)));
                default: imem[i] = {6'h02, 26'(i + 1 + $urandom_range(0, 3))};
            endcase
        end
        for (int r = 1; r < 8; r++) imem[30+r] = i_ins(6'h2B, 5'd0, 5'(r), 16'(124 + 4*r));
    endtask

    initial begin
        total = 0; bad = 0; trace_on = 1; last_fetch = 32'h0;
        reset = 1'b1; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        bus.imem_rdata = 32'h0; bus.dmem_rdata = 32'h0;
        for (int i = 0; i < 64; i++) dmem[i] = $urandom;
        @(negedge clk);

        // ALU chain, LED store/load, $0 handling, signed slt; zero-wait timing.
        clear_imem();
        imem[0]  = i_ins(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1]  = i_ins(6'h08, 5'd0, 5'd2, 16'hFFFD);
        imem[2]  = r_ins(6'h20, 5'd1, 5'd2, 5'd3);
        imem[3]  = i_ins(6'h2B, 5'd0, 5'd3, 16'hFF00);
        imem[4]  = i_ins(6'h23, 5'd0, 5'd4, 16'hFF00);
        imem[5]  = i_ins(6'h2B, 5'd0, 5'd4, 16'h0010);
        imem[6]  = r_ins(6'h20, 5'd1, 5'd1, 5'd0);
        imem[7]  = r_ins(6'h2A, 5'd2, 5'd1, 5'd5);
        imem[8]  = i_ins(6'h2B, 5'd0, 5'd5, 16'h0014);
        imem[9]  = i_ins(6'h2B, 5'd0, 5'd0, 16'h0018);
        set_waits(0, 0, 0, 0);
        start_prog();
        repeat (11) tick();
        check("alu3_c11_retire", n_retire, 2);
        tick();
        check("alu3_c12_retire", n_retire, 3);
        finish_prog(400);
        check("led_value", {24'h0, leds}, 32'h2);
        check("led_no_dmem", dm_req_cycles, 3);
        check("lw_led_back", dmem[4], 32'h2);
        check("slt_signed", dmem[5], 32'h1);
        check("r0_zero", dmem[6], 32'h0);

        // lw whose ack arrives after 3 wait cycles.
        clear_imem();
        imem[0] = i_ins(6'h23, 5'd0, 5'd1, 16'h0020);
        imem[1] = i_ins(6'h2B, 5'd0, 5'd1, 16'h0024);
        set_waits(0, 0, 3, 3);
        start_prog();
        repeat (7) tick();
        check("lw_wait_c7_retire", n_retire, 0);
        tick();
        check("lw_wait_c8_retire", n_retire, 1);
        check("lw_wait_req_cycles", dm_req_cycles, 4);
        finish_prog(400);
        check("lw_wait_data", dmem[9], dmem[8]);

        // beq to itself: refetch of the same PC every 3 cycles.
        clear_imem();
        imem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd7);
        imem[1] = i_ins(6'h04, 5'd1, 5'd1, 16'hFFFF);
        set_waits(0, 0, 0, 0);
        trace_on = 0;
        do_reset();
        repeat (4) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("beq_loop_pc", last_fetch, 32'h4);
            tick(); tick();
            check("beq_loop_retire", n_retire, 2 + k);
        end
        trace_on = 1;

        // bne not taken falls through to PC+4.
        clear_imem();
        imem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd7);
        imem[1] = i_ins(6'h05, 5'd1, 5'd1, 16'd5);
        imem[2] = i_ins(6'h2B, 5'd0, 5'd1, 16'h0030);
        start_prog();
        finish_prog(400);
        check("bne_fall_store", dmem[12], 32'h7);

        // Reset while a load is waiting for its ack.
        clear_imem();
        imem[0] = i_ins(6'h23, 5'd0, 5'd2, 16'h0028);
        set_waits(0, 0, 10, 10);
        trace_on = 0;
        do_reset();
        repeat (5) tick();
        check("midlw_req_before", {31'b0, bus.dmem_req}, 32'h1);
        do_reset();
        tick();
        check("midlw_refetch_pc", last_fetch, RESET_PC);
        check("midlw_no_dmem", dm_req_cycles, 0);
        trace_on = 1;

        // Random programs with random wait states.
        set_waits(0, 2, 0, 2);
        for (int p = 0; p < 6; p++) begin
            gen_prog();
            start_prog();
            finish_prog(3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
